// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states,
// byte-lane mask constants and small op-classification helpers.
package lsu_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LH  = 3'd1,
        OP_LW  = 3'd2,
        OP_LBU = 3'd3,
        OP_LHU = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } lsu_state_e;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath: load extraction/extension, store-word merge for
// read-modify-write, and the address-alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] raw_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word,
    output logic        misaligned
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = raw_word[7:0];
        case (offset)
            2'd1:    ld_byte = raw_word[15:8];
            2'd2:    ld_byte = raw_word[23:16];
            2'd3:    ld_byte = raw_word[31:24];
            default: ld_byte = raw_word[7:0];
        endcase
        ld_half = offset[1] ? raw_word[31:16] : raw_word[15:0];
    end

    // Non-store ops leave merged_word as the plain store data so the whole
    // store operand is consumed; only SB/SH splice into the fetched word.
    always_comb begin
        load_value  = '0;
        merged_word = store_data;
        case (op)
            OP_LB:  load_value = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU: load_value = {24'h0, ld_byte};
            OP_LH:  load_value = {{16{ld_half[15]}}, ld_half};
            OP_LHU: load_value = {16'h0, ld_half};
            OP_LW:  load_value = raw_word;
            OP_SB: begin
                merged_word = raw_word;
                merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
            end
            OP_SH: begin
                merged_word = raw_word;
                merged_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            end
            default: begin
                load_value  = '0;
                merged_word = store_data;
            end
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: misaligned = offset[0];
            OP_LW, OP_SW:         misaligned = |offset;
            default:              misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the data memory; sub-word
// stores at a non-zero offset are performed as an atomic read-modify-write.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    output logic        resp_wen,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        mem_ce,
    output logic        mem_we,
    output logic        mem_rr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_w_mask,
    output logic [3:0]  mem_r_mask,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state;
    lsu_state_e  state_next;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [4:0]  rd_q;
    logic        err_q;

    logic        accept;
    logic [2:0]  align_op;
    logic [1:0]  align_off;
    logic [31:0] load_value;
    logic [31:0] merged_word;
    logic        misaligned;

    assign accept = (state == S_IDLE) && req_valid;

    // In IDLE the aligner checks the incoming request; afterwards it works on
    // the latched request so load extraction and merging see stable operands.
    assign align_op  = (state == S_IDLE) ? req_op : op_q;
    assign align_off = (state == S_IDLE) ? req_addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .op          (align_op),
        .offset      (align_off),
        .raw_word    (word_q),
        .store_data  (wdata_q),
        .load_value  (load_value),
        .merged_word (merged_word),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                err_q   <= misaligned;
            end
            if ((state == S_LOAD) || (state == S_RMW_RD)) begin
                word_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (misaligned) begin
                        state_next = S_RESP;
                    end else if (!is_store(req_op)) begin
                        state_next = S_LOAD;
                    end else if ((req_op == OP_SW) || (req_addr[1:0] == 2'b00)) begin
                        state_next = S_STORE;
                    end else begin
                        state_next = S_RMW_RD;
                    end
                end
            end
            S_LOAD:   state_next = S_RESP;
            S_STORE:  state_next = S_RESP;
            S_RMW_RD: state_next = S_RMW_WR;
            S_RMW_WR: state_next = S_RESP;
            S_RESP:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    assign mem_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        req_ready  = (state == S_IDLE);
        resp_valid = 1'b0;
        resp_wen   = 1'b0;
        resp_data  = '0;
        resp_rd    = '0;
        resp_err   = 1'b0;
        mem_ce     = 1'b0;
        mem_we     = 1'b0;
        mem_rr     = 1'b0;
        mem_wdata  = '0;
        mem_w_mask = '0;
        mem_r_mask = '0;
        case (state)
            S_LOAD, S_RMW_RD: begin
                mem_ce     = 1'b1;
                mem_rr     = 1'b1;
                mem_r_mask = MASK_W;
            end
            S_STORE: begin
                mem_ce    = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = wdata_q;
                case (op_q)
                    OP_SB:   mem_w_mask = MASK_B;
                    OP_SH:   mem_w_mask = MASK_H;
                    default: mem_w_mask = MASK_W;
                endcase
            end
            S_RMW_WR: begin
                mem_ce     = 1'b1;
                mem_we     = 1'b1;
                mem_wdata  = merged_word;
                mem_w_mask = MASK_W;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rd    = rd_q;
                resp_err   = err_q;
                resp_wen   = !err_q && !is_store(op_q);
                resp_data  = resp_wen ? load_value : 32'h0;
            end
            default: begin
                req_ready = (state == S_IDLE);
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-masked 4 KB memory model
// and hand-computed expectations.
module tb_load_store_unit;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd3;
    localparam logic [2:0] SB  = 3'd5;
    localparam logic [2:0] SH  = 3'd6;
    localparam logic [2:0] SW  = 3'd7;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_wen;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_ce;
    logic        mem_we;
    logic        mem_rr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_w_mask;
    logic [3:0]  mem_r_mask;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];

    int n_asserts = 0;
    int n_fail    = 0;

    int          lat;
    logic [31:0] r_data;
    logic        r_wen;
    logic        r_err;
    logic [4:0]  r_rd;
    int          ce_cycles;
    int          we_cycles;
    int          rr_cycles;
    logic [3:0]  last_wmask;
    logic [31:0] last_wdata;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_wen   (resp_wen),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_err   (resp_err),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_rr     (mem_rr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_w_mask (mem_w_mask),
        .mem_r_mask (mem_r_mask),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_ce && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_w_mask[b]) begin
                    mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic mem_set(input logic [31:0] a, input logic [31:0] d);
        mem[a[11:2]] = d;
    endtask

    // One request from an idle unit; records what the memory port did and the
    // response, then steps back into IDLE.
    task automatic do_req(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
        logic got;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        got        = 1'b0;
        lat        = 0;
        ce_cycles  = 0;
        we_cycles  = 0;
        rr_cycles  = 0;
        last_wmask = '0;
        last_wdata = '0;
        for (int i = 1; i <= 10 && !got; i++) begin
            if (mem_ce) ce_cycles++;
            if (mem_rr) rr_cycles++;
            if (mem_we) begin
                we_cycles++;
                last_wmask = mem_w_mask;
                last_wdata = mem_wdata;
            end
            if (resp_valid) begin
                got    = 1'b1;
                lat    = i;
                r_data = resp_data;
                r_wen  = resp_wen;
                r_err  = resp_err;
                r_rd   = resp_rd;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            check({tag, "_timeout"}, 32'h0, 32'h1);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_resp(input string tag, input logic [31:0] exp_data, input logic exp_wen,
                              input logic exp_err, input logic [4:0] exp_rd);
        check({tag, "_data"}, r_data, exp_data);
        check({tag, "_wen_err_rd"}, {25'h0, r_wen, r_err, r_rd}, {25'h0, exp_wen, exp_err, exp_rd});
    endtask

    logic [2:0]  bb_op    [3];
    logic [31:0] bb_addr  [3];
    logic [31:0] bb_wdata [3];
    logic [4:0]  bb_rd    [3];
    logic [31:0] bb_data  [3];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idx;
        int resp_cnt;
        int resp_seen;
        logic acc;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_rd    = '0;

        // Reset state
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp", {25'h0, resp_valid, resp_wen, resp_err, resp_rd}, 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_mem_ctrl", {21'h0, mem_ce, mem_we, mem_rr, mem_w_mask, mem_r_mask}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Loads with sign/zero extension
        $display("[TB] loads");
        mem_set(32'h10, 32'h80FF7F01);
        do_req("lb11", LB, 32'h11, 32'h0, 5'd1);
        check("lb11_lat", lat, 2);
        check_resp("lb11", 32'h0000007F, 1'b1, 1'b0, 5'd1);
        check("lb11_rr", rr_cycles, 1);
        do_req("lbu13", LBU, 32'h13, 32'h0, 5'd2);
        check("lbu13_lat", lat, 2);
        check_resp("lbu13", 32'h00000080, 1'b1, 1'b0, 5'd2);
        do_req("lh12", LH, 32'h12, 32'h0, 5'd3);
        check("lh12_lat", lat, 2);
        check_resp("lh12", 32'hFFFF80FF, 1'b1, 1'b0, 5'd3);
        do_req("lw10", LW, 32'h10, 32'h0, 5'd4);
        check("lw10_lat", lat, 2);
        check_resp("lw10", 32'h80FF7F01, 1'b1, 1'b0, 5'd4);

        // Direct stores
        $display("[TB] direct stores");
        mem_set(32'h20, 32'h11223344);
        do_req("sb20", SB, 32'h20, 32'h000000AB, 5'd5);
        check("sb20_lat", lat, 2);
        check("sb20_we", {we_cycles[27:0], last_wmask}, {28'd1, 4'b0001});
        check_resp("sb20", 32'h0, 1'b0, 1'b0, 5'd5);
        check("sb20_mem", mem[8], 32'h112233AB);
        do_req("sh20", SH, 32'h20, 32'h0000BEEF, 5'd6);
        check("sh20_we", {we_cycles[27:0], last_wmask}, {28'd1, 4'b0011});
        check("sh20_mem", mem[8], 32'h1122BEEF);
        do_req("sw24", SW, 32'h24, 32'hCAFEBABE, 5'd7);
        check("sw24_lat", lat, 2);
        check("sw24_we", {we_cycles[27:0], last_wmask}, {28'd1, 4'b1111});
        check("sw24_wdata", last_wdata, 32'hCAFEBABE);
        check("sw24_mem", mem[9], 32'hCAFEBABE);

        // Read-modify-write stores
        $display("[TB] read-modify-write stores");
        mem_set(32'h30, 32'h11223344);
        do_req("sb32", SB, 32'h32, 32'h000000AA, 5'd8);
        check("sb32_lat", lat, 3);
        check("sb32_rd_wr", {rr_cycles[15:0], we_cycles[15:0]}, {16'd1, 16'd1});
        check("sb32_wmask", {28'h0, last_wmask}, 32'hF);
        check("sb32_mem", mem[12], 32'h11AA3344);
        do_req("sh32", SH, 32'h32, 32'h00005566, 5'd9);
        check("sh32_lat", lat, 3);
        check("sh32_mem", mem[12], 32'h55663344);
        check_resp("sh32", 32'h0, 1'b0, 1'b0, 5'd9);

        // Misaligned requests
        $display("[TB] misaligned");
        mem_set(32'h40, 32'h0BADF00D);
        do_req("lh41", LH, 32'h41, 32'h0, 5'd10);
        check_resp("lh41", 32'h0, 1'b0, 1'b1, 5'd10);
        check("lh41_ce", ce_cycles, 0);
        do_req("lw42", LW, 32'h42, 32'h0, 5'd11);
        check_resp("lw42", 32'h0, 1'b0, 1'b1, 5'd11);
        check("lw42_ce", ce_cycles, 0);
        do_req("sw43", SW, 32'h43, 32'hFFFFFFFF, 5'd12);
        check_resp("sw43", 32'h0, 1'b0, 1'b1, 5'd12);
        check("sw43_ce", ce_cycles, 0);
        check("sw43_mem", mem[16], 32'h0BADF00D);

        // Back-to-back with req_valid held high
        $display("[TB] back-to-back");
        bb_op[0] = LW; bb_addr[0] = 32'h10; bb_wdata[0] = 32'h0;        bb_rd[0] = 5'd13; bb_data[0] = 32'h80FF7F01;
        bb_op[1] = SW; bb_addr[1] = 32'h50; bb_wdata[1] = 32'h12345678; bb_rd[1] = 5'd14; bb_data[1] = 32'h0;
        bb_op[2] = LB; bb_addr[2] = 32'h53; bb_wdata[2] = 32'h0;        bb_rd[2] = 5'd15; bb_data[2] = 32'h00000012;
        @(negedge clk);
        idx       = 0;
        resp_cnt  = 0;
        req_valid = 1'b1;
        req_op    = bb_op[0];
        req_addr  = bb_addr[0];
        req_wdata = bb_wdata[0];
        req_rd    = bb_rd[0];
        for (int c = 0; c < 9; c++) begin
            check($sformatf("bb_ready_%0d", c), {31'h0, req_ready}, (c % 3 == 0) ? 32'h1 : 32'h0);
            acc = req_ready;
            if (resp_valid) begin
                if (resp_cnt < 3) begin
                    check($sformatf("bb_rd_%0d", resp_cnt), {27'h0, resp_rd}, {27'h0, bb_rd[resp_cnt]});
                    check($sformatf("bb_data_%0d", resp_cnt), resp_data, bb_data[resp_cnt]);
                end
                resp_cnt++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    req_op    = bb_op[idx];
                    req_addr  = bb_addr[idx];
                    req_wdata = bb_wdata[idx];
                    req_rd    = bb_rd[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("bb_resp_count", resp_cnt, 3);
        check("bb_mem", mem[20], 32'h12345678);

        // Reset during RMW_RD of a sub-word store
        $display("[TB] reset mid-operation");
        mem_set(32'h60, 32'hDEADBEEF);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = SB;
        req_addr  = 32'h61;
        req_wdata = 32'h00000077;
        req_rd    = 5'd16;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rmwrd_ctrl", {29'h0, mem_ce, mem_we, mem_rr}, {29'h0, 3'b101});
        #1;
        rst = 1'b1;
        #1;
        check("rstmid_mem_ctrl", {21'h0, mem_ce, mem_we, mem_rr, mem_w_mask, mem_r_mask}, 32'h0);
        check("rstmid_resp", {30'h0, resp_valid, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        resp_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        check("rstmid_no_resp", resp_seen, 0);
        check("rstmid_mem", mem[24], 32'hDEADBEEF);
        do_req("lw60", LW, 32'h60, 32'h0, 5'd17);
        check("lw60_lat", lat, 2);
        check_resp("lw60", 32'hDEADBEEF, 1'b1, 1'b0, 5'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
